alu_operand_stage: RTL

- Registered operand/control staging buffer directly upstream of the 32-bit inverter and adder slice of the MIPS ALU.
- Accepts A, B and the 3-bit MIPS ALU control over a valid/ready handshake.
- Decodes the B-invert and carry-in controls that select inverted B for sub/slt.
- Presents the registered operands to the inverter/adder stage.
- Uses a 2-entry skid buffer, so full throughput is kept and the upstream handshake path stays registered.

---
 rtl/alu_operand_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand/control staging buffer in front of the ALU inverter/adder slice.
// Two-entry skid buffer (main M drives outputs, skid S absorbs one extra op)
// so in_ready is a flop yet full throughput is kept. ALU control decode is
// done at capture and stored with each entry.
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_binvert,
  output logic              out_cin,
  output logic              out_slt,
  output logic              out_illegal
);

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [CTRL_W-1:0] ctrl;
    logic              binvert;
    logic              cin;
    logic              slt;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q, state_d;
  entry_t m_q, m_d, s_q, s_d;
  logic   in_ready_q, in_ready_d;
  entry_t in_ent;
  logic   in_acc, out_fire;

  // Decode the incoming control into the entry that will be captured
  always_comb begin
    in_ent         = '0;
    in_ent.a       = in_a;
    in_ent.b       = in_b;
    in_ent.ctrl    = in_ctrl;
    in_ent.slt     = (in_ctrl == 3'b111);
    in_ent.binvert = (in_ctrl == 3'b110) || (in_ctrl == 3'b111);
    in_ent.cin     = in_ent.binvert;
    in_ent.illegal = (in_ctrl == 3'b011) || (in_ctrl == 3'b100) || (in_ctrl == 3'b101);
  end

  // in_ready_q is low exactly in FULL, so no input is taken there
  assign in_acc   = in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && out_ready;

  // Next-state and data-movement decisions
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: if (in_acc) begin
        m_d     = in_ent;
        state_d = ONE;
      end
      ONE: begin
        if (out_fire && in_acc) begin
          m_d = in_ent;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_acc) begin
          s_d     = in_ent;
          state_d = FULL;
        end
      end
      FULL: if (out_fire) begin
        m_d     = s_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // State and storage registers; reset discards both entries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Outputs come straight from registers only
  always_comb begin
    in_ready    = in_ready_q;
    out_valid   = (state_q != EMPTY);
    out_a       = m_q.a;
    out_b       = m_q.b;
    out_ctrl    = m_q.ctrl;
    out_binvert = m_q.binvert;
    out_cin     = m_q.cin;
    out_slt     = m_q.slt;
    out_illegal = m_q.illegal;
  end

endmodule
